// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed display scanner.
// Each digit is held for DIV cycles. The first BLANK cycles of each hold are
// dark, so the previous digit's segments cannot ghost onto the next select.
// New frames wait in a one-deep pending buffer. They move to the active frame
// only at the end of a full scan, so a displayed frame is never torn.
module seg_scan #(
  parameter int DIGITS   = 8,
  parameter int DATA_LEN = 4,
  parameter int DIV      = 1024,
  parameter int BLANK    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIGITS*DATA_LEN-1:0]   in_data,
  input  logic [DIGITS-1:0]            in_dp,
  input  logic [DIGITS-1:0]            in_en,
  output logic                         out_valid,
  output logic [DATA_LEN-1:0]          out_digit,
  output logic                         out_p,
  output logic [DIGITS-1:0]            out_sel,
  output logic [$clog2(DIGITS)-1:0]    out_idx
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic                       full;
  logic [DIGITS*DATA_LEN-1:0] pend_data;
  logic [DIGITS-1:0]          pend_dp;
  logic [DIGITS-1:0]          pend_en;
  logic [DIGITS*DATA_LEN-1:0] act_data;
  logic [DIGITS-1:0]          act_dp;
  logic [DIGITS-1:0]          act_en;

  logic cnt_last;
  logic frame_end;
  logic accept;
  logic commit;
  logic show;

  assign cnt_last  = (cnt == CNT_LAST);
  assign frame_end = cnt_last && (idx == IDX_LAST);
  // Ready is held low during reset. Nothing can be captured while the block is being cleared.
  assign in_ready  = !rst && !full;
  assign accept    = in_valid && in_ready;
  // Commit needs full=1 and accept needs full=0, so the two never happen on the same edge.
  assign commit    = frame_end && full;

  // Dwell counter, scan index, frame hand-over and buffer occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      full     <= 1'b0;
      act_data <= '0;
      act_dp   <= '0;
      act_en   <= '0;
    end else begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
      if (cnt_last) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (commit) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        act_en   <= pend_en;
        full     <= 1'b0;
      end else if (accept) begin
        full <= 1'b1;
      end
    end
  end

  // Pending buffer capture. Its contents only matter while full is set, so reset leaves it alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_data <= in_data;
      pend_dp   <= in_dp;
      pend_en   <= in_en;
    end
  end

  assign show    = (cnt >= BLANK_C) && act_en[idx];
  assign out_idx = idx;

  // Drive the digit outputs only from registered state. Blank everything outside the lit window.
  always_comb begin
    out_valid = 1'b0;
    out_digit = '0;
    out_p     = 1'b0;
    out_sel   = '1;
    if (show) begin
      out_valid    = 1'b1;
      out_digit    = act_data[idx*DATA_LEN +: DATA_LEN];
      out_p        = act_dp[idx];
      out_sel[idx] = 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Testbench for seg_scan with DIGITS=8, DATA_LEN=4, DIV=4, BLANK=1.
// The reference model tracks one position counter over the whole scan frame,
// plus the active and pending frames. Expected outputs are computed from that counter.
module tb_seg_scan;

  localparam int DIGITS   = 8;
  localparam int DATA_LEN = 4;
  localparam int DIV      = 4;
  localparam int BLANK    = 1;
  localparam int FRAME    = DIV * DIGITS;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_dp;
  logic [7:0]  in_en;
  logic        out_valid;
  logic [3:0]  out_digit;
  logic        out_p;
  logic [7:0]  out_sel;
  logic [2:0]  out_idx;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_t;
  bit          m_full;
  logic [31:0] m_pd, m_ad;
  logic [7:0]  m_pdp, m_adp, m_pen, m_aen;

  seg_scan #(
    .DIGITS(DIGITS), .DATA_LEN(DATA_LEN), .DIV(DIV), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dp(in_dp), .in_en(in_en),
    .out_valid(out_valid), .out_digit(out_digit), .out_p(out_p),
    .out_sel(out_sel), .out_idx(out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for the current position.
  task automatic compare_all(input logic r);
    int c, i;
    bit sh;
    logic [7:0] esel;
    c  = m_t % DIV;
    i  = m_t / DIV;
    sh = (c >= BLANK) && m_aen[i];
    esel = sh ? ~(8'd1 << i) : 8'hFF;
    check("out_valid", {31'd0, out_valid}, {31'd0, sh});
    check("out_digit", {28'd0, out_digit}, sh ? ((m_ad >> (4 * i)) & 32'hF) : 32'd0);
    check("out_p",     {31'd0, out_p}, sh ? {31'd0, m_adp[i]} : 32'd0);
    check("out_sel",   {24'd0, out_sel}, {24'd0, esel});
    check("out_idx",   {29'd0, out_idx}, i);
    check("in_ready",  {31'd0, in_ready}, {31'd0, (!r && !m_full)});
    check("sel_onehot", {31'd0, (out_sel == 8'hFF) || ($countones(~out_sel) == 1)}, 32'd1);
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic [7:0] dp, input logic [7:0] en);
    bit acc, com;
    rst = r; in_valid = v; in_data = d; in_dp = dp; in_en = en;
    @(posedge clk);
    if (r) begin
      m_t = 0; m_full = 0; m_ad = '0; m_adp = '0; m_aen = '0;
    end else begin
      acc = v && !m_full;
      com = (m_t == FRAME - 1) && m_full;
      if (com) begin
        m_ad = m_pd; m_adp = m_pdp; m_aen = m_pen; m_full = 0;
      end
      if (acc) begin
        m_pd = d; m_pdp = dp; m_pen = en; m_full = 1;
      end
      m_t = (m_t + 1) % FRAME;
    end
    #1;
    compare_all(r);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'hDEAD_BEEF, 8'hAA, 8'h55);
  endtask

  // Step idle cycles until the model reaches a frame position showing a given active frame.
  task automatic run_until(input int pos, input logic [31:0] want, input string tag);
    int k = 0;
    while (!(m_t == pos && m_ad == want) && k < 200) begin
      idle();
      k++;
    end
    check(tag, {31'd0, (m_t == pos && m_ad == want)}, 32'd1);
  endtask

  initial begin
    m_t = 0; m_full = 0;
    m_pd = '0; m_pdp = '0; m_pen = '0; m_ad = '0; m_adp = '0; m_aen = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dp = '0; in_en = '0;

    // Reset for two cycles, then check ready in the first cycle after release.
    step(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    step(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sel", {24'd0, out_sel}, 32'hFF);
    check("rst_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // First frame. A second offer while the buffer is full must be ignored.
    step(1'b0, 1'b1, 32'h1234_5678, 8'h01, 8'hFF);
    check("ready_full", {31'd0, in_ready}, 32'd0);
    step(1'b0, 1'b1, 32'hAAAA_AAAA, 8'hFF, 8'hFF);
    run_until(0, 32'h1234_5678, "commit1_timeout");
    check("ready_after_commit", {31'd0, in_ready}, 32'd1);
    check("d0_blank_valid", {31'd0, out_valid}, 32'd0);
    idle();
    check("d0_digit", {28'd0, out_digit}, 32'd8);
    check("d0_p", {31'd0, out_p}, 32'd1);
    check("d0_sel", {24'd0, out_sel}, 32'hFE);
    idle(); idle(); idle(); idle();
    check("d1_digit", {28'd0, out_digit}, 32'd7);
    check("d1_p", {31'd0, out_p}, 32'd0);
    check("d1_sel", {24'd0, out_sel}, 32'hFD);

    // Second frame with upper digits disabled. It appears one frame later.
    step(1'b0, 1'b1, 32'h9ABC_DEF0, 8'hF0, 8'h0F);
    run_until(17, 32'h9ABC_DEF0, "commit2_timeout");
    check("en_off_valid", {31'd0, out_valid}, 32'd0);
    check("en_off_sel", {24'd0, out_sel}, 32'hFF);
    check("en_off_idx", {29'd0, out_idx}, 32'd4);

    // Load pending, then reset at idx 5 while the buffer is full.
    step(1'b0, 1'b1, 32'h5555_5555, 8'hFF, 8'hFF);
    idle(); idle();
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    check("pre_rst_idx", {29'd0, out_idx}, 32'd5);
    step(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    check("mid_rst_idx", {29'd0, out_idx}, 32'd0);
    check("mid_rst_sel", {24'd0, out_sel}, 32'hFF);
    // Free run: no commit may happen, so the display stays dark while the index wraps.
    for (int k = 0; k < 40; k++) begin
      idle();
      check("free_dark", {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 250) == 0, ($urandom % 5) == 0, $urandom,
           8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
